// File: rtl/dcache_inval_sequencer_if.sv
// Tag/valid SRAM write port between the invalidation sequencer and the tag-SRAM arbiter.
// Latency: none (wires only); one access completes on each cycle with req_o & gnt_i.
// Backpressure: the arbiter withholds gnt_i; the requester holds req_o/addr_o until granted.
interface dcache_inval_sequencer_if #(
    parameter int unsigned SetW    = 8,
    parameter int unsigned NumWays = 8
);
    logic               req_o;
    logic               gnt_i;
    logic               we_o;
    logic [SetW-1:0]    addr_o;
    logic [NumWays-1:0] way_en_o;

    // Sequencer side: drives the write strobe, set index and way enables.
    modport master (
        output req_o,
        output we_o,
        output addr_o,
        output way_en_o,
        input  gnt_i
    );

    // Arbiter side: observes the request and returns the grant.
    modport slave (
        input  req_o,
        input  we_o,
        input  addr_o,
        input  way_en_o,
        output gnt_i
    );
endinterface

// File: rtl/dcache_inval_sequencer.sv
// Sweeps valid=0 into every way of every dcache set after reset and on each flush request.
// Latency: one set per granted access; flush ack one cycle after the last grant (+drain cycles).
// Backpressure: a withheld gnt_i holds the set index; pending refills delay the sweep start.
module dcache_inval_sequencer #(
    // Defaults match the reference core configuration (DCACHE_NUM_WORDS / DCACHE_SET_ASSOC).
    parameter int unsigned  NumSets = 256,
    parameter int unsigned  NumWays = 8,
    localparam int unsigned SetW    = (NumSets > 1) ? $clog2(NumSets) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic flush_ack_o,
    input  logic pending_refill_i,
    output logic block_o,
    output logic init_done_o,
    output logic busy_o,
    dcache_inval_sequencer_if.master sram_if
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_SWEEP,
        ST_ACK
    } state_e;

    localparam logic [SetW-1:0] LastIdx = SetW'(NumSets - 1);

    state_e          state_q, state_d;
    logic [SetW-1:0] idx_q, idx_d;
    logic            init_done_q, init_done_d;

    logic            req;
    logic            block;
    logic            ack;
    logic            last_set;

    assign last_set = (idx_q == LastIdx);

    // State, set counter and sticky init flag; reset restarts the post-reset sweep from set 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state and output decode; the counter only advances on a granted access and
    // stops at the last set, so non-power-of-2 set counts never alias.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        req         = 1'b0;
        block       = 1'b0;
        ack         = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                req   = 1'b1;
                block = 1'b1;
                if (sram_if.gnt_i) begin
                    if (last_set) begin
                        init_done_d = 1'b1;
                        // The sweep just finished already covers a flush raised meanwhile.
                        state_d     = flush_i ? ST_ACK : ST_IDLE;
                    end else begin
                        idx_d = idx_q + SetW'(1);
                    end
                end
            end

            ST_IDLE: begin
                if (flush_i) begin
                    if (pending_refill_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_SWEEP;
                        idx_d   = '0;
                    end
                end
            end

            ST_DRAIN: begin
                // Refill data would land in a line we are about to invalidate: let it finish.
                block = 1'b1;
                if (!pending_refill_i) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end

            ST_SWEEP: begin
                // pending_refill_i cannot rise here because block_o holds the miss unit off.
                req   = 1'b1;
                block = 1'b1;
                if (sram_if.gnt_i) begin
                    if (last_set) begin
                        state_d = ST_ACK;
                    end else begin
                        idx_d = idx_q + SetW'(1);
                    end
                end
            end

            ST_ACK: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    assign sram_if.req_o    = req;
    assign sram_if.we_o     = req;
    assign sram_if.addr_o   = idx_q;
    assign sram_if.way_en_o = {NumWays{req}};

    assign flush_ack_o = ack;
    assign block_o     = block;
    assign busy_o      = (state_q != ST_IDLE);
    assign init_done_o = init_done_q;

    // The requester must keep flush_i high until it sees the ack.
    a_flush_held : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ((state_q == ST_DRAIN) || (state_q == ST_SWEEP)) |-> flush_i
    ) else $error("flush_i dropped before flush_ack_o");

endmodule

// File: tb/tb_dcache_inval_sequencer.sv
// Bench for dcache_inval_sequencer: three instances (4 sets/4 ways, 256 sets/8 ways, 1 set/2 ways).
// Expected behaviour: each sweep is NumSets granted writes to sets 0..NumSets-1 in order,
// preceded by one drain cycle per cycle of pending refill, followed by a single ack cycle.
module tb_dcache_inval_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        flush [3];
    logic        pend  [3];
    logic        gnt   [3];
    logic        ack   [3];
    logic        blk   [3];
    logic        done  [3];
    logic        busy  [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wen   [3];

    int unsigned nsets [3] = '{4, 256, 1};
    logic [31:0] wmask [3] = '{32'h0000_000F, 32'h0000_00FF, 32'h0000_0003};

    int checks = 0;
    int errors = 0;

    dcache_inval_sequencer_if #(.SetW(2), .NumWays(4)) if0 ();
    dcache_inval_sequencer_if #(.SetW(8), .NumWays(8)) if1 ();
    dcache_inval_sequencer_if #(.SetW(1), .NumWays(2)) if2 ();

    assign if0.gnt_i = gnt[0];
    assign if1.gnt_i = gnt[1];
    assign if2.gnt_i = gnt[2];
    assign req[0] = if0.req_o;  assign we[0] = if0.we_o;
    assign req[1] = if1.req_o;  assign we[1] = if1.we_o;
    assign req[2] = if2.req_o;  assign we[2] = if2.we_o;
    assign addr[0] = 32'(if0.addr_o);  assign wen[0] = 32'(if0.way_en_o);
    assign addr[1] = 32'(if1.addr_o);  assign wen[1] = 32'(if1.way_en_o);
    assign addr[2] = 32'(if2.addr_o);  assign wen[2] = 32'(if2.way_en_o);

    dcache_inval_sequencer #(.NumSets(4), .NumWays(4)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .flush_ack_o(ack[0]),
        .pending_refill_i(pend[0]), .block_o(blk[0]), .init_done_o(done[0]),
        .busy_o(busy[0]), .sram_if(if0)
    );
    dcache_inval_sequencer #(.NumSets(256), .NumWays(8)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .flush_ack_o(ack[1]),
        .pending_refill_i(pend[1]), .block_o(blk[1]), .init_done_o(done[1]),
        .busy_o(busy[1]), .sram_if(if1)
    );
    dcache_inval_sequencer #(.NumSets(1), .NumWays(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .flush_ack_o(ack[2]),
        .pending_refill_i(pend[2]), .block_o(blk[2]), .init_done_o(done[2]),
        .busy_o(busy[2]), .sram_if(if2)
    );

    // Walks one sweep (INIT or SWEEP) starting at a negedge where the first access is visible.
    // gmode: 0 random grants (+ random illegal refill noise), 1 grant tied high, 2 pattern 1,0,0.
    task automatic sweep_loop(input int d, input int gmode, input string tag);
        int k = 0;
        int stall = 0;
        int cyc = 0;
        bit g;
        while (k < int'(nsets[d])) begin
            checks++;
            if ({req[d], we[d], blk[d], busy[d], ack[d]} !== 5'b11110) begin
                errors++;
                $display("FAIL %s d%0d set%0d req/we/blk/busy/ack got %b%b%b%b%b want 11110",
                         tag, d, k, req[d], we[d], blk[d], busy[d], ack[d]);
            end
            checks++;
            if (addr[d] !== 32'(k)) begin
                errors++;
                $display("FAIL %s d%0d addr got %0d want %0d", tag, d, addr[d], k);
            end
            checks++;
            if (wen[d] !== wmask[d]) begin
                errors++;
                $display("FAIL %s d%0d way_en got %h want %h", tag, d, wen[d], wmask[d]);
            end
            case (gmode)
                0:       g = ($urandom_range(0, 2) != 0) || (stall >= 4);
                1:       g = 1'b1;
                default: g = ((cyc % 3) == 0);
            endcase
            if (gmode == 0) pend[d] = 1'($urandom_range(0, 1));
            gnt[d] = g;
            if (g) begin
                k++;
                stall = 0;
            end else begin
                stall++;
            end
            cyc++;
            @(negedge clk);
        end
        gnt[d]  = 1'b0;
        pend[d] = 1'b0;
    endtask

    // One flush transaction with p cycles of pending refill; keep leaves flush_i high past the ack.
    task automatic run_flush(input int d, input int p, input int gmode, input bit keep);
        checks++;
        if (busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL flush_start d%0d busy got %b want 0", d, busy[d]);
        end
        flush[d] = 1'b1;
        pend[d]  = (p > 0);
        gnt[d]   = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < p; i++) begin
            checks++;
            if ({req[d], blk[d], busy[d], ack[d]} !== 4'b0110) begin
                errors++;
                $display("FAIL drain d%0d cyc%0d req/blk/busy/ack got %b%b%b%b want 0110",
                         d, i, req[d], blk[d], busy[d], ack[d]);
            end
            pend[d] = (i < p - 1);
            gnt[d]  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        sweep_loop(d, gmode, "flush_sweep");
        checks++;
        if ({ack[d], busy[d], req[d], blk[d]} !== 4'b1100 || wen[d] !== 32'h0) begin
            errors++;
            $display("FAIL flush_ack d%0d ack/busy/req/blk got %b%b%b%b way_en %h want 1100 0",
                     d, ack[d], busy[d], req[d], blk[d], wen[d]);
        end
        if (!keep) flush[d] = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack[d], busy[d], req[d], blk[d]} !== 4'b0000) begin
            errors++;
            $display("FAIL flush_idle d%0d ack/busy/req/blk got %b%b%b%b want 0000",
                     d, ack[d], busy[d], req[d], blk[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            flush[d] = 1'b0; pend[d] = 1'b0; gnt[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({req[d], we[d], blk[d], busy[d], ack[d], done[d]} !== 6'b111100) begin
                errors++;
                $display("FAIL reset d%0d req/we/blk/busy/ack/done got %b%b%b%b%b%b want 111100",
                         d, req[d], we[d], blk[d], busy[d], ack[d], done[d]);
            end
            checks++;
            if (addr[d] !== 32'h0 || wen[d] !== wmask[d]) begin
                errors++;
                $display("FAIL reset_addr d%0d addr %0d way_en %h want 0 %h",
                         d, addr[d], wen[d], wmask[d]);
            end
        end
    endtask

    // Releases reset with all grants low, then completes each instance's INIT sweep in turn.
    task automatic test_init_sweep();
        for (int d = 0; d < 3; d++) gnt[d] = 1'b0;
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (done[d] !== 1'b0) begin
                errors++;
                $display("FAIL init_pre d%0d init_done got %b want 0", d, done[d]);
            end
            sweep_loop(d, 1, "init_sweep");
            checks++;
            if ({done[d], busy[d], req[d], ack[d], blk[d]} !== 5'b10000) begin
                errors++;
                $display("FAIL init_done d%0d done/busy/req/ack/blk got %b%b%b%b%b want 10000",
                         d, done[d], busy[d], req[d], ack[d], blk[d]);
            end
        end
        @(negedge clk);
        checks++;
        if (req[0] !== 1'b0 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL init_stays d0 req %b done %b want 0 1", req[0], done[0]);
        end
    endtask

    task automatic test_flush_during_init();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) gnt[d] = 1'b0;
        flush[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL init_flush_rst init_done got %b want 0", done[0]);
        end
        rst_n = 1'b1;
        sweep_loop(0, 0, "init_flush");
        checks++;
        if ({ack[0], done[0], busy[0], req[0]} !== 4'b1110) begin
            errors++;
            $display("FAIL init_flush_ack ack/done/busy/req got %b%b%b%b want 1110",
                     ack[0], done[0], busy[0], req[0]);
        end
        flush[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack[0], busy[0], req[0], done[0]} !== 4'b0001) begin
            errors++;
            $display("FAIL init_flush_idle ack/busy/req/done got %b%b%b%b want 0001",
                     ack[0], busy[0], req[0], done[0]);
        end
        sweep_loop(1, 1, "init_rest");
        sweep_loop(2, 1, "init_rest");
    endtask

    task automatic test_reset_mid_sweep();
        flush[0] = 1'b1;
        pend[0]  = 1'b0;
        gnt[0]   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            gnt[0] = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (addr[0] !== 32'd2 || req[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre addr %0d req %b want 2 1", addr[0], req[0]);
        end
        rst_n    = 1'b0;
        flush[0] = 1'b0;
        gnt[0]   = 1'b1;
        #1;
        checks++;
        if ({req[0], we[0], blk[0], busy[0], ack[0], done[0]} !== 6'b111100 ||
            addr[0] !== 32'h0 || wen[0] !== wmask[0]) begin
            errors++;
            $display("FAIL midrst req/we/blk/busy/ack/done got %b%b%b%b%b%b addr %0d want 111100 0",
                     req[0], we[0], blk[0], busy[0], ack[0], done[0], addr[0]);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) gnt[d] = 1'b0;
        rst_n = 1'b1;
        sweep_loop(0, 1, "midrst_init");
        checks++;
        if ({done[0], ack[0], busy[0]} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_done done/ack/busy got %b%b%b want 100", done[0], ack[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_noack ack got %b want 0", ack[0]);
        end
        sweep_loop(1, 1, "midrst_rest");
        sweep_loop(2, 1, "midrst_rest");
    endtask

    task automatic test_flush_timing();
        run_flush(1, 0, 1, 1'b0);
    endtask

    task automatic test_drain();
        run_flush(0, 5, 1, 1'b0);
    endtask

    task automatic test_gnt_pattern();
        run_flush(0, 0, 2, 1'b0);
    endtask

    task automatic test_single_set();
        run_flush(2, 0, 1, 1'b0);
        run_flush(2, 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_flush(0, 0, 1, 1'b1);
        run_flush(0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int d;
            int p;
            int gm;
            bit keep;
            d    = $urandom_range(0, 2);
            p    = $urandom_range(0, 6);
            gm   = $urandom_range(0, 2);
            keep = ($urandom_range(0, 3) == 0);
            run_flush(d, p, gm, keep);
            if (keep) run_flush(d, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            flush[d] = 1'b0; pend[d] = 1'b0; gnt[d] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_init_sweep();
        test_flush_timing();
        test_drain();
        test_gnt_pattern();
        test_single_set();
        test_back_to_back();
        test_flush_during_init();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_inval_sequencer.md
# dcache_inval_sequencer

Sequences whole-array invalidation of the write-through data cache tag/valid SRAM. It runs one invalidation sweep automatically after reset and another on each flush request (fence / fence.i). A sweep writes valid=0 to every way of every set, one set per granted SRAM access. The block sits beside the dcache miss unit as one requester of the tag-SRAM arbiter, and blocks new misses while a sweep is pending or running.

## Interface
Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_t (build-time default), core configuration.
- NumSets, CVA6Cfg.DCACHE_NUM_WORDS, number of sets to sweep; overridable for test, must be ≥1.
- NumWays, CVA6Cfg.DCACHE_SET_ASSOC, associativity.
- SetW, max(1, $clog2(NumSets)), set index width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- flush_i  in  1  level flush request; held high until flush_ack_o is seen.
- flush_ack_o  out  1  one-cycle pulse: the requested sweep is complete.
- pending_refill_i  in  1  the miss unit has an in-flight refill.
- block_o  out  1  the miss unit must not start new refills.
- init_done_o  out  1  sticky; high once the post-reset sweep completes.
- busy_o  out  1  the block is in any state other than IDLE.
- req_o  out  1  tag-SRAM write request.
- gnt_i  in  1  arbiter grant; an access completes on req_o & gnt_i.
- we_o  out  1  equals req_o; every access is a write.
- addr_o  out  SetW  set index being invalidated.
- way_en_o  out  NumWays  all ones while req_o=1, else zero.

## Operation
- States: INIT, IDLE, DRAIN, SWEEP, ACK.
- Set counter idx (SetW bits):
  - Cleared on entry to SWEEP and by reset.
  - Increments on req_o & gnt_i when idx ≠ NumSets-1.
  - Never wraps past NumSets-1; non-power-of-2 NumSets is legal.
- Write data is the all-zero valid vector and is driven by the SRAM wrapper; the block supplies only address, way enables and strobe.
- INIT (reset state): req_o=1, addr_o=idx. On a grant with idx=NumSets-1:
  - set init_done_o;
  - go to ACK if flush_i=1 (the sweep just done satisfies the pending flush), else go to IDLE.
- IDLE: if flush_i=1:
  - pending_refill_i=0 → SWEEP;
  - pending_refill_i=1 → DRAIN.
- DRAIN: wait until pending_refill_i=0, then SWEEP. No SRAM requests are issued.
- SWEEP: same access rule as INIT. A grant at idx=NumSets-1 → ACK.
- ACK: flush_ack_o=1 for exactly one cycle, then IDLE.
- Output decode by state:
  - block_o=1 in INIT, DRAIN and SWEEP.
  - req_o=1 only in INIT and SWEEP.
  - busy_o = (state ≠ IDLE).
- A request whose flush_i is still high in the IDLE cycle after ACK is treated as a new flush.
- flush_i dropping before its ack is a protocol violation. The sweep still completes and the ack is still issued. An assertion flags it in simulation.
- pending_refill_i rising during SWEEP cannot occur legally, because block_o is high; it is ignored.

## Timing
- Reset values (while rst_ni=0):
  - state=INIT, idx=0;
  - req_o=1, we_o=1, addr_o=0, way_en_o all ones;
  - block_o=1, busy_o=1;
  - init_done_o=0, flush_ack_o=0.
  - gnt_i is ignored during reset.
- Reset asserted mid-sweep: immediately aborts the sweep and restarts INIT from idx 0. A pending flush is not acked separately.
- Post-reset sweep with gnt_i tied high:
  - accesses at idx 0..NumSets-1 in the first NumSets cycles after reset release;
  - init_done_o rises on the next edge.
- Flush with gnt_i tied high and pending_refill_i=0, flush_i first sampled high in IDLE at cycle t:
  - req_o high in cycles t+1 .. t+NumSets;
  - flush_ack_o in cycle t+NumSets+1;
  - IDLE in cycle t+NumSets+2.
- Each cycle with req_o=1 and gnt_i=0 holds addr_o and idx unchanged and extends the sweep by one cycle.
- DRAIN adds exactly as many cycles as pending_refill_i stays high.
- NumSets=1: a single access per sweep; ack one cycle after its grant.

## Test plan
- Reset release, NumSets=4, gnt_i=1 → addr_o 0,1,2,3 on consecutive cycles; init_done_o=1 on cycle 4; req_o=0 from then on.
- Flush in IDLE, NumSets=256, gnt_i=1 → 256 writes with way_en_o=8'hFF; flush_ack_o at t+257 for exactly one cycle; busy_o low at t+258.
- Flush with pending_refill_i high for 5 cycles → no req_o for 5 cycles, block_o=1 throughout; then a full sweep and an ack.
- gnt_i toggling 1,0,0,1,… (NumSets=4) → addr_o holds on every no-grant cycle; exactly 4 granted accesses; ack one cycle after the last grant.
- flush_i high during INIT → no second sweep; flush_ack_o the cycle after the final INIT grant, with init_done_o=1 in the same cycle.
- rst_ni asserted at idx=2 of a flush sweep → outputs at reset values immediately; a new INIT sweep starts from 0; no flush_ack_o is issued.
